// File: rtl/prefetch_master.sv
// Single-word instruction prefetcher with a Wishbone pipelined master port.
// Fetches one word at a time, presents it to the CPU and, on acceptance,
// streams on to the next sequential word. CPU redirects abort any bus
// cycle in flight by dropping cyc for one cycle before the new request.
module prefetch_master #(
  parameter int unsigned ADDRESS_WIDTH = 30
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  // CPU side
  input  logic                     i_new_pc,
  input  logic                     i_clear_cache,
  input  logic [ADDRESS_WIDTH+1:0] i_pc,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [31:0]              o_insn,
  output logic [ADDRESS_WIDTH+1:0] o_pc,
  output logic                     o_illegal,
  // Wishbone pipelined master
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
  output logic [31:0]              o_wb_data,
  output logic [3:0]               o_wb_sel,
  input  logic                     i_wb_stall,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err,
  input  logic [31:0]              i_wb_data
);

  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned PW = ADDRESS_WIDTH + 2;

  typedef enum logic [2:0] {
    StIdle,
    StRestart,
    StReq,
    StWait,
    StHold,
    StFault
  } state_e;

  state_e          state_q;
  logic            cyc_q;
  logic            stb_q;
  logic            valid_q;
  logic            illegal_q;
  logic [PW-1:0]   pc_q;
  logic [31:0]     insn_q;

  // Next sequential word address; wraps modulo 2^AW.
  logic [AW-1:0]   pc_word_inc;

  // Word address of the following instruction.
  always_comb begin
    pc_word_inc = pc_q[PW-1:2] + AW'(1);
  end

  // Fetch sequencer. Clear has priority over a redirect, which has priority
  // over normal progress; all outputs are registered here.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
      insn_q    <= '0;
    end else if (i_clear_cache) begin
      state_q   <= StIdle;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (i_new_pc) begin
      pc_q      <= i_pc;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      if (cyc_q) begin
        // Abort the outstanding cycle; its response must not be taken.
        state_q <= StRestart;
        cyc_q   <= 1'b0;
        stb_q   <= 1'b0;
      end else begin
        state_q <= StReq;
        cyc_q   <= 1'b1;
        stb_q   <= 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          cyc_q <= 1'b0;
          stb_q <= 1'b0;
        end
        StRestart: begin
          // Any ack/err seen here belongs to the aborted cycle.
          state_q <= StReq;
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
        end
        StReq: begin
          if (!i_wb_stall) begin
            state_q <= StWait;
            stb_q   <= 1'b0;
          end
        end
        StWait: begin
          // Error wins over a simultaneous ack.
          if (i_wb_err) begin
            state_q   <= StFault;
            cyc_q     <= 1'b0;
            valid_q   <= 1'b1;
            illegal_q <= 1'b1;
          end else if (i_wb_ack) begin
            state_q <= StHold;
            cyc_q   <= 1'b0;
            valid_q <= 1'b1;
            insn_q  <= i_wb_data;
          end
        end
        StHold: begin
          if (i_ready) begin
            state_q <= StReq;
            pc_q    <= {pc_word_inc, 2'b00};
            valid_q <= 1'b0;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
          end
        end
        StFault: begin
          // Sticky until redirect, clear or reset.
          valid_q   <= 1'b1;
          illegal_q <= 1'b1;
        end
        default: begin
          state_q   <= StIdle;
          cyc_q     <= 1'b0;
          stb_q     <= 1'b0;
          valid_q   <= 1'b0;
          illegal_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_valid   = valid_q;
  assign o_illegal = illegal_q;
  assign o_insn    = insn_q;
  assign o_pc      = pc_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_addr = pc_q[PW-1:2];
  assign o_wb_we   = 1'b0;
  assign o_wb_data = 32'h0;
  assign o_wb_sel  = 4'hf;

endmodule
